// File: rtl/full_adder_ha.sv
// Registered ripple-carry adder: {C,S} = X + Y + Z, one cycle of latency.
// Each bit is a full-adder cell made of two half adders and an OR.
// Operands are taken every cycle; there is no handshake and no stall.

// Half adder: sum = a ^ b, carry = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module full_adder_ha #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Z,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_comb;

  assign carry_chain[0] = Z;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic p;
    logic g1;
    logic g2;

    // First half adder: propagate and generate from the operand bits.
    half_adder u_ha1 (
      .a     (X[i]),
      .b     (Y[i]),
      .sum   (p),
      .carry (g1)
    );

    // Second half adder: fold in the incoming carry.
    half_adder u_ha2 (
      .a     (p),
      .b     (carry_chain[i]),
      .sum   (sum_comb[i]),
      .carry (g2)
    );

    assign carry_chain[i+1] = g1 | g2;
  end

  // Capture the combinational sum each edge; reset wins over the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      S <= '0;
      C <= 1'b0;
    end else begin
      S <= sum_comb;
      C <= carry_chain[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder_ha.sv
// Bench for full_adder_ha: three instances (WIDTH 1, 4, 8) share clk/rst.
// An arithmetic model predicts each cycle's outputs; directed vectors add
// hand-computed literal expectations for reset, truth table and boundaries.
module tb_full_adder_ha;

  logic       clk;
  logic       rst;
  logic [0:0] x1, y1;
  logic       z1;
  logic [3:0] x4, y4;
  logic       z4;
  logic [7:0] x8, y8;
  logic       z8;
  logic [0:0] s1;
  logic       c1;
  logic [3:0] s4;
  logic       c4;
  logic [7:0] s8;
  logic       c8;

  int n_checks = 0;
  int n_bad    = 0;

  full_adder_ha #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .X(x1), .Y(y1), .Z(z1), .S(s1), .C(c1)
  );
  full_adder_ha #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .X(x4), .Y(y4), .Z(z4), .S(s4), .C(c4)
  );
  full_adder_ha #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .X(x8), .Y(y8), .Z(z8), .S(s8), .C(c8)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: at each edge the result is either zero (reset) or plain X+Y+Z.
  logic [1:0] exp1_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] exp8_q[$];
  bit started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      exp1_q.push_back('0);
      exp4_q.push_back('0);
      exp8_q.push_back('0);
    end else if (started) begin
      exp1_q.push_back(2'(int'(x1) + int'(y1) + int'(z1)));
      exp4_q.push_back(5'(int'(x4) + int'(y4) + int'(z4)));
      exp8_q.push_back(9'(int'(x8) + int'(y8) + int'(z8)));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every falling edge, compare registered outputs with the model.
  always @(negedge clk) begin
    if (exp1_q.size() > 0) begin
      logic [1:0] e1;
      logic [4:0] e4;
      logic [8:0] e8;
      e1 = exp1_q.pop_front();
      e4 = exp4_q.pop_front();
      e8 = exp8_q.pop_front();
      check("model_w1", {62'd0, c1, s1}, {62'd0, e1});
      check("model_w4", {59'd0, c4, s4}, {59'd0, e4});
      check("model_w8", {55'd0, c8, s8}, {55'd0, e8});
    end
  end

  // Driver helpers: advance one edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_all();
    x1 = 1'($urandom_range(1, 0)); y1 = 1'($urandom_range(1, 0)); z1 = 1'($urandom_range(1, 0));
    x4 = 4'($urandom_range(15, 0)); y4 = 4'($urandom_range(15, 0)); z4 = 1'($urandom_range(1, 0));
    x8 = 8'($urandom_range(255, 0)); y8 = 8'($urandom_range(255, 0)); z8 = 1'($urandom_range(1, 0));
  endtask

  task automatic w4_vec(input logic [3:0] x, input logic [3:0] y, input logic z,
                        input logic [3:0] es, input logic ec, input string name);
    x4 = x; y4 = y; z4 = z;
    step();
    check(name, {59'd0, c4, s4}, {59'd0, ec, es});
  endtask

  logic tt_s[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic tt_c[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset for two cycles with all-ones operands and carry-in.
    rst = 1'b1;
    x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
    x4 = 4'hF; y4 = 4'hF; z4 = 1'b1;
    x8 = 8'hFF; y8 = 8'hFF; z8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_w1", {62'd0, c1, s1}, 64'd0);
      check("reset_w4", {59'd0, c4, s4}, 64'd0);
      check("reset_w8", {55'd0, c8, s8}, 64'd0);
    end

    // First edge without reset loads the applied sum.
    rst = 1'b0;
    step();
    check("first_w8", {55'd0, c8, s8}, {55'd0, 1'b1, 8'hFF});
    check("first_w4", {59'd0, c4, s4}, {59'd0, 1'b1, 4'hF});

    // WIDTH=1 truth table on consecutive cycles; wider instances get random data.
    for (int i = 0; i < 8; i++) begin
      rand_all();
      {x1, y1, z1} = 3'(i);
      step();
      check($sformatf("tt_%0d", i), {62'd0, c1, s1}, {62'd0, tt_c[i], tt_s[i]});
    end

    // WIDTH=4 boundary and ripple vectors.
    w4_vec(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, "w4_f0_1");
    w4_vec(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "w4_ff_1");
    w4_vec(4'h5, 4'hA, 1'b0, 4'hF, 1'b0, "w4_5a_0");
    w4_vec(4'h5, 4'hA, 1'b1, 4'h0, 1'b1, "w4_5a_1");
    w4_vec(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, "w4_zero");

    // WIDTH=8 all-ones and all-zero boundaries.
    x8 = 8'hFF; y8 = 8'hFF; z8 = 1'b1;
    step();
    check("w8_ones", {55'd0, c8, s8}, {55'd0, 1'b1, 8'hFF});
    x8 = 8'h00; y8 = 8'h00; z8 = 1'b0;
    step();
    check("w8_zero", {55'd0, c8, s8}, 64'd0);

    // Changing inputs with a single reset cycle in the middle.
    for (int i = 0; i < 4; i++) begin
      rand_all();
      step();
    end
    rand_all();
    x8 = 8'h80; y8 = 8'h80; z8 = 1'b1;
    rst = 1'b1;
    step();
    check("mid_rst_w8", {55'd0, c8, s8}, 64'd0);
    check("mid_rst_w4", {59'd0, c4, s4}, 64'd0);
    rst = 1'b0;
    x8 = 8'h12; y8 = 8'h34; z8 = 1'b1;
    step();
    check("post_rst_w8", {55'd0, c8, s8}, {55'd0, 1'b0, 8'h47});

    // Random soak, checked by the model every cycle.
    for (int i = 0; i < 1000; i++) begin
      rand_all();
      step();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/full_adder_ha.md
FULL_ADDER_HA -- requirements
Module: full_adder_ha

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 X  input  WIDTH  addend operand A.
REQ-005 Y  input  WIDTH  addend operand B.
REQ-006 Z  input  1  carry-in (Cin).
REQ-007 S  output  WIDTH  registered sum.
REQ-008 C  output  1  registered carry-out.
REQ-009 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.

Function
REQ-010 The block SHALL compute {C,S} = X + Y + Z as an unsigned (WIDTH+1)-bit result, with no truncation and no overflow flag beyond C.
REQ-011 Each bit position SHALL be a full-adder cell built from two half-adder cells plus an OR:
- HA1: p = x^y, g1 = x&y
- HA2: s = p^cin, g2 = p&cin
- cout = g1|g2
REQ-012 The half adder SHALL be a separate submodule (sum = a^b, carry = a&b), instantiated twice per bit.
REQ-013 Cells SHALL chain ripple-carry: bit 0 cin = Z; bit i cin = bit i-1 cout; C = bit WIDTH-1 cout.
REQ-014 The addition path from X/Y/Z to the S/C register inputs SHALL be purely combinational, with no internal state.
REQ-015 S and C SHALL be registered on the rising edge of clk with exactly 1-cycle latency: inputs sampled at edge n appear on S/C after edge n and hold until edge n+1.
REQ-016 A new operand set SHALL be accepted every cycle (throughput 1/cycle, no handshake, no stall).
REQ-017 Outputs SHALL be a pure function of the last sampled inputs; no dependence on earlier inputs.
REQ-018 Boundary case: all-ones X and Y with Z=1 SHALL give S = all ones, C = 1.
REQ-019 Boundary case: all-zero X and Y with Z=0 SHALL give S = 0, C = 0.
REQ-020 For WIDTH=1, outputs SHALL follow the full-adder truth table (XYZ -> S C): 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
REQ-021 X/Y/Z containing X/Z states SHALL NOT be relied on; behaviour is only required for 0/1 inputs.

Reset
REQ-022 While rst=1 at a rising edge, S SHALL become 0 and C SHALL become 0, regardless of X/Y/Z.
REQ-023 Reset SHALL take priority over the addition result on the same edge.
REQ-024 On the first rising edge with rst=0, S/C SHALL load the sum of the inputs sampled at that edge.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; no partial or stale value appears after reset.
REQ-026 Before the first reset edge, output values are unspecified.

Verification
REQ-027 WIDTH=1, rst=1 for 2 cycles with X=Y=Z=1 -> S=0, C=0 during reset.
REQ-028 WIDTH=1, apply all 8 XYZ combinations 000..111 on consecutive cycles -> each S/C matches REQ-020 exactly one cycle later.
REQ-029 WIDTH=4:
- X=4'hF, Y=4'h0, Z=1 -> S=4'h0, C=1
- X=4'hF, Y=4'hF, Z=1 -> S=4'hF, C=1
REQ-030 WIDTH=4, X=4'h5, Y=4'hA, Z=0 -> S=4'hF, C=0 (no carry ripple); then Z=1 -> S=4'h0, C=1 (full ripple).
REQ-031 Back-to-back changing inputs with rst=1 asserted for one cycle in the middle -> outputs 0 for that cycle, correct sums resume on the next cycle.
REQ-032 Random 1000-vector test with WIDTH=8 -> {C,S} equals X+Y+Z of the previous cycle's inputs, zero mismatches.
